unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the core's instruction-fetch port and its data (MEM-stage) port.
//  Per cycle: grants at most one request, drives the memory, and returns read data one cycle later, tagged to its owner.
//  Data port has priority; a starvation counter forces an instruction grant after MAX_WAIT blocked cycles.
//  Sits between the pipeline top and the memory; an ungranted requester must stall its stage.
// PARAMETERS
//  ADDR_W    12  byte-address width of both ports and the memory
//  MAX_WAIT  3   consecutive denied I-cycles before the forced I grant (1..15)
// PORTS
//  CLK        in   1       clock, all state on posedge
//  RST        in   1       asynchronous reset, active-high
//  I_REQ      in   1       fetch request; held until I_GNT
//  I_ADDR     in   ADDR_W  fetch byte address
//  I_GNT      out  1       fetch accepted this cycle (combinational)
//  I_RVALID   out  1       I_RDATA valid (cycle after I_GNT)
//  I_RDATA    out  32      fetched word
//  D_REQ      in   1       data request; held until D_GNT
//  D_WE       in   1       1 = store, 0 = load
//  D_BE       in   4       store byte enables
//  D_ADDR     in   ADDR_W  data byte address
//  D_WDATA    in   32      store data
//  D_GNT      out  1       data accepted this cycle (combinational)
//  D_RVALID   out  1       D_RDATA valid (cycle after a granted load)
//  D_RDATA    out  32      loaded word
//  M_CSN      out  1       memory chip select, active-low
//  M_WEN      out  1       memory write enable, active-low
//  M_BE       out  4       memory byte enables
//  M_ADDR     out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  M_DOUT     out  32      write data to memory
//  M_DI       in   32      read data from memory, valid one cycle after issue
//  STARVE     out  1       forced-I-grant state active
// BEHAVIOUR
//  Reset (RST=1, async): state=IDLE, wait_cnt=0, owner reg=NONE; I_GNT=D_GNT=0, RVALIDs=0, RDATAs=0,
//   M_CSN=1, M_WEN=1, M_BE=0, M_ADDR=0, M_DOUT=0, STARVE=0; grants forced 0 while RST is high.
//  FSM states (registered, = owner of the previous grant): IDLE, I_OWN, D_OWN, I_FORCE.
//   I_FORCE when wait_cnt==MAX_WAIT: I_REQ wins over D_REQ; leaves I_FORCE on the I grant, or to IDLE if I_REQ drops.
//   Otherwise: D_REQ -> D_GNT, next D_OWN; else I_REQ -> I_GNT, next I_OWN; else next IDLE.
//  wait_cnt: +1 (saturating at MAX_WAIT) each cycle I_REQ=1 and I_GNT=0; cleared on I_GNT or I_REQ=0.
//  Issue cycle: M_CSN=0 and M_* driven combinationally from the winner; D store -> M_WEN=0, M_BE=D_BE;
//   any read -> M_WEN=1, M_BE=4'b1111. No grant -> M_CSN=1, M_WEN=1.
//  Response: a registered rsp tag (I / D-load / none) plus M_DI routed next cycle; I_RVALID or D_RVALID high one cycle.
//   RDATA holds its last value when not valid. Stores produce no RVALID.
//  Throughput: one access per cycle, back-to-back grants allowed; read latency is exactly 1 cycle.
//  Simultaneous I_REQ & D_REQ outside I_FORCE -> D wins; inside I_FORCE -> I wins, D_GNT=0 that cycle.
//  A request dropped before its grant is legal; nothing is issued for it.
//  Reset mid-access: the pending response is discarded, and no RVALID follows the deassertion of RST.
//  STARVE = (state==I_FORCE) or (wait_cnt==MAX_WAIT), registered.
// CONFIGURATION
//  UMA_PERF_CNT_EN defined: adds out ports CONFLICT_CNT[31:0] (+1 each cycle both REQs are high)
//   and FORCE_CNT[15:0] (+1 per forced I grant). Both reset to 0 on RST, wrap on overflow.
//  Undefined: those ports and counters are absent; arbitration behaviour is identical.
// TESTING
//  1 I_REQ only, I_ADDR=0x010, M_DI=0xDEADBEEF -> I_GNT same cycle, M_ADDR=0x010, M_CSN=0; next cycle I_RVALID=1, I_RDATA=0xDEADBEEF.
//  2 D store D_ADDR=0x103, D_BE=0011, D_WDATA=0x1234 -> M_ADDR=0x100, M_WEN=0, M_BE=0011, M_DOUT=0x1234; no D_RVALID.
//  3 I_REQ and D_REQ (loads) held 6 cycles, MAX_WAIT=3 -> D,D,D,I,D,D grants; STARVE=1 around the forced grant; each RVALID matches its owner.
//  4 Back-to-back D load then I fetch, M_DI=0xA then 0xB -> D_RDATA=0xA and I_RDATA=0xB on consecutive cycles, no cross-routing.
//  5 RST asserted the cycle after a granted load -> all outputs return to reset values immediately; no RVALID after release.
//  6 UMA_PERF_CNT_EN on, scenario 3 -> CONFLICT_CNT=6, FORCE_CNT=1; build with the macro off compiles and scenarios 1-5 still pass.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline (fetch + MEM stage), the arbiter and the
// single-port memory.
//   slave  : arbiter view (takes requests and read data, drives grants,
//            responses and the memory command)
//   master : environment view (pipeline requesters plus the memory model)
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 12
);
  // instruction-fetch port
  logic              I_REQ;
  logic [ADDR_W-1:0] I_ADDR;
  logic              I_GNT;
  logic              I_RVALID;
  logic [31:0]       I_RDATA;
  // data (MEM-stage) port
  logic              D_REQ;
  logic              D_WE;
  logic [3:0]        D_BE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [31:0]       D_WDATA;
  logic              D_GNT;
  logic              D_RVALID;
  logic [31:0]       D_RDATA;
  // memory side
  logic              M_CSN;
  logic              M_WEN;
  logic [3:0]        M_BE;
  logic [ADDR_W-1:0] M_ADDR;
  logic [31:0]       M_DOUT;
  logic [31:0]       M_DI;

  modport slave (
    input  I_REQ, I_ADDR,
    output I_GNT, I_RVALID, I_RDATA,
    input  D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
    output D_GNT, D_RVALID, D_RDATA,
    output M_CSN, M_WEN, M_BE, M_ADDR, M_DOUT,
    input  M_DI
  );

  modport master (
    output I_REQ, I_ADDR,
    input  I_GNT, I_RVALID, I_RDATA,
    output D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
    input  D_GNT, D_RVALID, D_RDATA,
    input  M_CSN, M_WEN, M_BE, M_ADDR, M_DOUT,
    output M_DI
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port and the data port. Data has priority; after MAX_WAIT
// consecutive denied fetch cycles the fetch port is granted ahead of data.
// Read data returns one cycle after the grant, routed to its owner.
// Optional: define UMA_PERF_CNT_EN to add CONFLICT_CNT / FORCE_CNT outputs.
module unified_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int MAX_WAIT = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  unified_mem_arbiter_if.slave  bus,
  output logic                  STARVE
`ifdef UMA_PERF_CNT_EN
  ,
  output logic [31:0]           CONFLICT_CNT,
  output logic [15:0]           FORCE_CNT
`endif
);

  typedef enum logic [1:0] {IDLE, I_OWN, D_OWN, I_FORCE} stateT;
  typedef enum logic [1:0] {RSP_NONE, RSP_I, RSP_D} rspT;

  localparam logic [3:0]        MAX_W     = 4'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  stateT       state, stateNext;
  rspT         rspTag, rspNext;
  logic [3:0]  waitCnt, waitNext;
  logic        iGnt, dGnt;
  logic [31:0] iHold, dHold;

  // State, starvation counter, response tag and STARVE flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      waitCnt <= '0;
      rspTag  <= RSP_NONE;
      STARVE  <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitNext;
      rspTag  <= rspNext;
      STARVE  <= (stateNext == I_FORCE) || (waitNext == MAX_W);
    end
  end

  // Arbitration, starvation counting and next-state selection
  always_comb begin
    iGnt      = 1'b0;
    dGnt      = 1'b0;
    waitNext  = '0;
    stateNext = IDLE;
    rspNext   = RSP_NONE;
    if (!RST) begin
      // In I_FORCE only the fetch port may win; a dropped fetch idles a cycle.
      if (state == I_FORCE)  iGnt = bus.I_REQ;
      else if (bus.D_REQ)    dGnt = 1'b1;
      else if (bus.I_REQ)    iGnt = 1'b1;
    end
    if (bus.I_REQ && !iGnt)
      waitNext = (waitCnt == MAX_W) ? MAX_W : waitCnt + 4'd1;
    // The forced state is entered as soon as the counter reaches its limit.
    if (waitNext == MAX_W) stateNext = I_FORCE;
    else if (iGnt)         stateNext = I_OWN;
    else if (dGnt)         stateNext = D_OWN;
    if (iGnt)                   rspNext = RSP_I;
    else if (dGnt && !bus.D_WE) rspNext = RSP_D;
  end

  // Memory command driven from the winning port
  always_comb begin
    bus.M_CSN  = 1'b1;
    bus.M_WEN  = 1'b1;
    bus.M_BE   = '0;
    bus.M_ADDR = '0;
    bus.M_DOUT = '0;
    if (dGnt) begin
      bus.M_CSN  = 1'b0;
      bus.M_WEN  = !bus.D_WE;
      bus.M_BE   = bus.D_WE ? bus.D_BE : 4'b1111;
      bus.M_ADDR = bus.D_ADDR & WORD_MASK;
      bus.M_DOUT = bus.D_WDATA;
    end else if (iGnt) begin
      bus.M_CSN  = 1'b0;
      bus.M_BE   = 4'b1111;
      bus.M_ADDR = bus.I_ADDR & WORD_MASK;
    end
  end

  // Grants go straight out to the requesters
  always_comb begin
    bus.I_GNT = iGnt;
    bus.D_GNT = dGnt;
  end

  // Hold registers keep the last delivered word for each port
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iHold <= '0;
      dHold <= '0;
    end else begin
      if (rspTag == RSP_I) iHold <= bus.M_DI;
      if (rspTag == RSP_D) dHold <= bus.M_DI;
    end
  end

  // Response routing: live memory data on the valid cycle, held data otherwise
  always_comb begin
    bus.I_RVALID = (rspTag == RSP_I);
    bus.D_RVALID = (rspTag == RSP_D);
    bus.I_RDATA  = (rspTag == RSP_I) ? bus.M_DI : iHold;
    bus.D_RDATA  = (rspTag == RSP_D) ? bus.M_DI : dHold;
  end

`ifdef UMA_PERF_CNT_EN
  // Performance counters: request conflicts and forced fetch grants
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CONFLICT_CNT <= '0;
      FORCE_CNT    <= '0;
    end else begin
      if (bus.I_REQ && bus.D_REQ)     CONFLICT_CNT <= CONFLICT_CNT + 32'd1;
      if (iGnt && (state == I_FORCE)) FORCE_CNT    <= FORCE_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the arbitration rules.
module tb_unified_mem_arbiter;
  localparam int ADDR_W   = 12;
  localparam int MAX_WAIT = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic STARVE;
`ifdef UMA_PERF_CNT_EN
  logic [31:0] CONFLICT_CNT;
  logic [15:0] FORCE_CNT;
`endif

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .STARVE       (STARVE)
`ifdef UMA_PERF_CNT_EN
    ,
    .CONFLICT_CNT (CONFLICT_CNT),
    .FORCE_CNT    (FORCE_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int nCompared = 0;
  int nFailed   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          denied = 0;   // consecutive cycles the fetch port waited
  int          pend   = 0;   // 0 none, 1 fetch word due, 2 load word due
  logic [31:0] iLast  = '0;
  logic [31:0] dLast  = '0;
  int          mConf  = 0;
  int          mForce = 0;

  always @(negedge CLK) begin : model
    bit forced, eI, eD;
    int a;
    if (RST) begin
      chk("rst I_GNT", 32'(bus.I_GNT), 0);
      chk("rst D_GNT", 32'(bus.D_GNT), 0);
      chk("rst I_RVALID", 32'(bus.I_RVALID), 0);
      chk("rst D_RVALID", 32'(bus.D_RVALID), 0);
      chk("rst I_RDATA", bus.I_RDATA, 0);
      chk("rst D_RDATA", bus.D_RDATA, 0);
      chk("rst M_CSN", 32'(bus.M_CSN), 1);
      chk("rst M_WEN", 32'(bus.M_WEN), 1);
      chk("rst M_BE", 32'(bus.M_BE), 0);
      chk("rst M_ADDR", 32'(bus.M_ADDR), 0);
      chk("rst M_DOUT", bus.M_DOUT, 0);
      chk("rst STARVE", 32'(STARVE), 0);
`ifdef UMA_PERF_CNT_EN
      chk("rst CONFLICT_CNT", CONFLICT_CNT, 0);
      chk("rst FORCE_CNT", 32'(FORCE_CNT), 0);
`endif
      denied = 0; pend = 0; iLast = '0; dLast = '0; mConf = 0; mForce = 0;
    end else begin
      forced = (denied >= MAX_WAIT);
      eI = forced ? bus.I_REQ : (bus.I_REQ && !bus.D_REQ);
      eD = forced ? 1'b0 : bus.D_REQ;
      chk("I_GNT", 32'(bus.I_GNT), 32'(eI));
      chk("D_GNT", 32'(bus.D_GNT), 32'(eD));
      chk("STARVE", 32'(STARVE), 32'(forced));
      chk("M_CSN", 32'(bus.M_CSN), 32'(!(eI || eD)));
      chk("M_WEN", 32'(bus.M_WEN), 32'(!(eD && bus.D_WE)));
      if (eI || eD) begin
        a = eD ? int'(bus.D_ADDR) : int'(bus.I_ADDR);
        chk("M_ADDR", 32'(bus.M_ADDR), 32'((a / 4) * 4));
        chk("M_BE", 32'(bus.M_BE), (eD && bus.D_WE) ? 32'(bus.D_BE) : 32'hF);
        if (eD && bus.D_WE) chk("M_DOUT", bus.M_DOUT, bus.D_WDATA);
      end
      chk("I_RVALID", 32'(bus.I_RVALID), 32'(pend == 1));
      chk("D_RVALID", 32'(bus.D_RVALID), 32'(pend == 2));
      chk("I_RDATA", bus.I_RDATA, (pend == 1) ? bus.M_DI : iLast);
      chk("D_RDATA", bus.D_RDATA, (pend == 2) ? bus.M_DI : dLast);
`ifdef UMA_PERF_CNT_EN
      chk("CONFLICT_CNT", CONFLICT_CNT, 32'(mConf));
      chk("FORCE_CNT", 32'(FORCE_CNT), 32'(mForce % 65536));
      if (bus.I_REQ && bus.D_REQ) mConf++;
      if (forced && eI) mForce++;
`endif
      // advance to the state after the coming rising edge
      if (pend == 1) iLast = bus.M_DI;
      if (pend == 2) dLast = bus.M_DI;
      pend = eI ? 1 : ((eD && !bus.D_WE) ? 2 : 0);
      if (bus.I_REQ && !eI) denied = (denied + 1 > MAX_WAIT) ? MAX_WAIT : denied + 1;
      else denied = 0;
    end
  end

  // ---------------- stimulus + literal expectations ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic atNeg();
    @(negedge CLK); #1;
  endtask

  task automatic idleIn();
    bus.I_REQ = 0; bus.D_REQ = 0; bus.D_WE = 0;
  endtask

  initial begin : stim
    string seq;
    bit iHeld, dHeld, gI, gD;
`ifdef UMA_PERF_CNT_EN
    logic [31:0] confBase;
    logic [15:0] forceBase;
`endif
    bus.I_REQ = 1; bus.I_ADDR = '0; bus.D_REQ = 1; bus.D_WE = 0; bus.D_BE = '0;
    bus.D_ADDR = '0; bus.D_WDATA = '0; bus.M_DI = '0;
    // grants stay low while reset is held even with both requests up
    atNeg();
    chk("reset I_GNT", 32'(bus.I_GNT), 0);
    chk("reset D_GNT", 32'(bus.D_GNT), 0);
    chk("reset M_CSN", 32'(bus.M_CSN), 1);
    tick();
    idleIn();
    RST = 0;

    // 1: lone fetch
    tick();
    bus.I_REQ = 1; bus.I_ADDR = 12'h010;
    atNeg();
    chk("s1 I_GNT", 32'(bus.I_GNT), 1);
    chk("s1 M_ADDR", 32'(bus.M_ADDR), 32'h010);
    chk("s1 M_CSN", 32'(bus.M_CSN), 0);
    tick();
    bus.I_REQ = 0; bus.M_DI = 32'hDEADBEEF;
    atNeg();
    chk("s1 I_RVALID", 32'(bus.I_RVALID), 1);
    chk("s1 I_RDATA", bus.I_RDATA, 32'hDEADBEEF);

    // 2: byte-enabled store to an unaligned address
    tick();
    bus.D_REQ = 1; bus.D_WE = 1; bus.D_BE = 4'b0011; bus.D_ADDR = 12'h103; bus.D_WDATA = 32'h1234;
    atNeg();
    chk("s2 D_GNT", 32'(bus.D_GNT), 1);
    chk("s2 M_ADDR", 32'(bus.M_ADDR), 32'h100);
    chk("s2 M_WEN", 32'(bus.M_WEN), 0);
    chk("s2 M_BE", 32'(bus.M_BE), 32'h3);
    chk("s2 M_DOUT", bus.M_DOUT, 32'h1234);
    tick();
    idleIn();
    atNeg();
    chk("s2 no D_RVALID", 32'(bus.D_RVALID), 0);

    // 3: both ports hold loads for 6 cycles -> D,D,D,I,D,D
    tick();
    bus.I_REQ = 1; bus.I_ADDR = 12'h200; bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 12'h300;
    seq = "";
    for (int c = 0; c < 6; c++) begin
      atNeg();
`ifdef UMA_PERF_CNT_EN
      if (c == 0) begin confBase = CONFLICT_CNT; forceBase = FORCE_CNT; end
`endif
      if (c == 0) chk("s3 STARVE before", 32'(STARVE), 0);
      if (c == 3) chk("s3 STARVE forced", 32'(STARVE), 1);
      chk("s3 I_GNT", 32'(bus.I_GNT), 32'(c == 3));
      chk("s3 D_GNT", 32'(bus.D_GNT), 32'(c != 3));
      tick();
    end
    idleIn();
    atNeg();
`ifdef UMA_PERF_CNT_EN
    chk("s3 CONFLICT_CNT delta", CONFLICT_CNT - confBase, 6);
    chk("s3 FORCE_CNT delta", 32'(FORCE_CNT - forceBase), 1);
`endif

    // 4: load then fetch back to back, no cross-routing
    tick();
    bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 12'h020;
    atNeg();
    chk("s4 D_GNT", 32'(bus.D_GNT), 1);
    tick();
    bus.D_REQ = 0; bus.I_REQ = 1; bus.I_ADDR = 12'h040; bus.M_DI = 32'hA;
    atNeg();
    chk("s4 I_GNT", 32'(bus.I_GNT), 1);
    chk("s4 D_RVALID", 32'(bus.D_RVALID), 1);
    chk("s4 D_RDATA", bus.D_RDATA, 32'hA);
    chk("s4 I_RVALID early", 32'(bus.I_RVALID), 0);
    tick();
    bus.I_REQ = 0; bus.M_DI = 32'hB;
    atNeg();
    chk("s4 I_RVALID", 32'(bus.I_RVALID), 1);
    chk("s4 I_RDATA", bus.I_RDATA, 32'hB);
    chk("s4 D_RVALID late", 32'(bus.D_RVALID), 0);
    chk("s4 D_RDATA held", bus.D_RDATA, 32'hA);

    // 5: reset right after a granted load discards the response
    tick();
    bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 12'h050;
    atNeg();
    chk("s5 D_GNT", 32'(bus.D_GNT), 1);
    tick();
    bus.D_REQ = 0; bus.M_DI = 32'h5555AAAA; RST = 1;
    atNeg();
    chk("s5 D_RVALID in reset", 32'(bus.D_RVALID), 0);
    chk("s5 D_RDATA in reset", bus.D_RDATA, 0);
    chk("s5 I_RDATA in reset", bus.I_RDATA, 0);
    tick();
    RST = 0;
    atNeg();
    chk("s5 D_RVALID after", 32'(bus.D_RVALID), 0);
    chk("s5 I_RVALID after", 32'(bus.I_RVALID), 0);

    // randomized traffic; requests mostly held until granted
    tick();
    iHeld = 0; dHeld = 0; gI = 0; gD = 0;
    for (int n = 0; n < 4000; n++) begin
      RST = ($urandom_range(0, 599) == 0);
      if (!iHeld || gI || $urandom_range(0, 19) == 0) begin
        iHeld = ($urandom_range(0, 99) < 60);
        bus.I_ADDR = ADDR_W'($urandom);
      end
      if (!dHeld || gD || $urandom_range(0, 19) == 0) begin
        dHeld = ($urandom_range(0, 99) < 55);
        bus.D_WE = $urandom_range(0, 1) == 1;
        bus.D_BE = 4'($urandom);
        bus.D_ADDR = ADDR_W'($urandom);
        bus.D_WDATA = $urandom;
      end
      bus.I_REQ = iHeld;
      bus.D_REQ = dHeld;
      bus.M_DI = $urandom;
      @(negedge CLK);
      gI = bus.I_GNT; gD = bus.D_GNT;
      tick();
    end
    RST = 0;
    idleIn();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
